run_detector: RTL and testbench
===============================

Name: run_detector

Overview:
- Parametrised successor to the lab's fixed four-in-a-row sequence detector.
- Tracks the length of the current run of identical serial bits on w and flags when it reaches RUN_LEN.
- Adds a sample-enable, a detection-polarity mode, a run-length readout and a detection pulse.
- Sits between a debounced switch/key input stage and the LED/7-seg display logic of the lab designs.

Parameters:
RUN_LEN, 4, run length that triggers detection; legal range 1..2^CNT_W-1
CNT_W, 4, width of run-length counter; the counter saturates at 2^CNT_W-1
EVT_W, 8, width of detection event counter (used only with optional feature)

Ports:
Clock  in  1  single system clock; all state updates on posedge
Resetn  in  1  reset, synchronous, active-low
En  in  1  sample strobe; w is consumed only on edges where En=1
w  in  1  serial data bit
Mode  in  2  detection mode: 00 ones or zeros, 01 ones only, 10 zeros only, 11 detection masked
z  out  1  run detected (level)
z_val  out  1  bit value of the current run
run_cnt  out  CNT_W  current run length, saturating
rise  out  1  one-cycle pulse on z 0->1
evt_cnt  out  EVT_W  detection count; present only with RUNDET_EVT_CNT_EN

Behaviour:
- Reset: on a posedge with Resetn=0, regardless of En:
  - state=EMPTY, run_cnt=0, z_val(last)=0, z_q=0.
  - Consequently z=0 and rise=0 in the following cycle.
- States:
  - EMPTY: no bit sampled since reset.
  - RUN: last holds the run value.
- Edge with En=1, state EMPTY: run_cnt<=1, last<=w, state<=RUN.
- Edge with En=1, state RUN, w!=last: run_cnt<=1, last<=w (new run starts at length 1, not 0).
- Edge with En=1, state RUN, w==last: run_cnt<=run_cnt+1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Once saturated, z holds for as long as the run continues.
- Edge with En=0: state, run_cnt, last and z_q all hold.
- z is combinational from registers: z = (state==RUN) && (run_cnt>=RUN_LEN) && mode_ok.
  - mode_ok: Mode=00 -> 1; 01 -> last==1; 10 -> last==0; 11 -> 0.
- Latency: z rises in the cycle immediately after the edge that samples the RUN_LEN-th identical bit. No additional pipeline delay.
- Mode is not registered. A change on Mode affects z in the same cycle and never alters run_cnt or last.
- z_q <= z on every edge, including edges where En=0. rise = z && !z_q.
  - rise is high for exactly one cycle per z assertion, including an assertion caused by a Mode change.
- A bit flip while z=1 deasserts z on the next cycle, because run_cnt=1 < RUN_LEN when RUN_LEN>1.
  - With RUN_LEN=1, z stays high; rise does not re-pulse because z never falls.
- z_val = last. It reads 0 in EMPTY.
- Reset mid-run takes priority over En/w on the same edge. The first bit after reset starts a fresh run at length 1.
- Elaboration check: RUN_LEN<1 or RUN_LEN>2^CNT_W-1 must raise an error. Implement with a generate-time $error or an equivalent illegal construct.

Optional Feature:
- Macro: RUNDET_EVT_CNT_EN.
- Defined:
  - Port evt_cnt[EVT_W-1:0] exists.
  - Reset value 0.
  - Increments by 1 on every edge where rise=1 (i.e. z_q<=1 while z_q was 0).
  - Wraps modulo 2^EVT_W.
  - Holds otherwise; En does not gate it.
- Undefined:
  - Port evt_cnt and its register are absent.
  - All other behaviour is identical.

Test Plan:
- Defaults, Mode=00, En=1, w=1,1,1,1 -> run_cnt=1,2,3,4; z=1 and rise=1 after 4th edge; rise=0 next cycle; z_val=1.
- Mode=01, w=0 x5 -> run_cnt=5, z=0. Switch Mode to 00 -> z=1 and rise=1 same cycle, run_cnt unchanged at 5.
- w=1,1,1,0,1,1,1,1 -> run_cnt resets to 1 at the 0; z first asserts only after the 8th edge.
- CNT_W=3, RUN_LEN=7, w=0 x10 -> run_cnt saturates at 7; z=1 from 7th edge on; single rise pulse.
- After 3 ones, hold En=0 for 5 cycles with w toggling -> run_cnt stays 3. Then En=1, w=1 -> z=1.
- Mid-run (run_cnt=4, z=1), Resetn=0 for one edge with En=1 -> run_cnt=0, z=0, z_val=0. With RUNDET_EVT_CNT_EN and EVT_W=2, five separate detections -> evt_cnt=1,2,3,0,1.

Source files
------------

// File: rtl/run_detector.sv
// -----------------------------------------------------------------------------
// run_detector
//
// Tracks the length of the current run of identical serial bits on w and
// flags when that run reaches RUN_LEN. Bits are consumed only on clock edges
// where En=1. Mode selects which run polarity may raise z, or masks detection.
// rise pulses for one cycle on every 0->1 transition of z.
//
// Parameters:
//   RUN_LEN  run length that triggers detection (1 .. 2**CNT_W-1)
//   CNT_W    width of the saturating run-length counter
//   EVT_W    width of the detection event counter (optional feature only)
//
// Optional feature:
//   RUNDET_EVT_CNT_EN  when defined, adds the evt_cnt port, a wrapping count
//                      of rise pulses.
//
// Ports:
//   Clock    in   1      system clock, all state updates on posedge
//   Resetn   in   1      synchronous active-low reset
//   En       in   1      sample strobe for w
//   w        in   1      serial data bit
//   Mode     in   2      00 ones or zeros, 01 ones only, 10 zeros only,
//                        11 detection masked
//   z        out  1      run detected (level)
//   z_val    out  1      bit value of the current run (0 before first sample)
//   run_cnt  out  CNT_W  current run length, saturating
//   rise     out  1      one-cycle pulse on z 0->1
//   evt_cnt  out  EVT_W  detection count (RUNDET_EVT_CNT_EN only)
// -----------------------------------------------------------------------------
module run_detector #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 4,
  parameter int EVT_W   = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             En,
  input  logic             w,
  input  logic [1:0]       Mode,
  output logic             z,
  output logic             z_val,
  output logic [CNT_W-1:0] run_cnt,
  output logic             rise
`ifdef RUNDET_EVT_CNT_EN
  ,
  output logic [EVT_W-1:0] evt_cnt
`endif
);

  // Reject configurations the counter cannot represent.
  generate
    if (RUN_LEN < 1 || RUN_LEN > (2 ** CNT_W) - 1 || EVT_W < 1) begin : g_bad_cfg
      $error("run_detector: RUN_LEN=%0d outside 1..%0d for CNT_W=%0d, or EVT_W<1",
             RUN_LEN, (2 ** CNT_W) - 1, CNT_W);
    end
  endgenerate

  localparam logic ST_EMPTY = 1'b0;  // nothing sampled since reset
  localparam logic ST_RUN   = 1'b1;  // last holds the current run value

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] RUN_THRESH = CNT_W'(RUN_LEN);

  logic             state;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic             z_q;
  logic             mode_ok;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    mode_ok = 1'b0;
    unique case (Mode)
      2'b00:   mode_ok = 1'b1;
      2'b01:   mode_ok = last;
      2'b10:   mode_ok = ~last;
      default: mode_ok = 1'b0;
    endcase
  end

  // Mode is deliberately unregistered: a mode change moves z in the same cycle.
  assign z       = (state == ST_RUN) && (cnt >= RUN_THRESH) && mode_ok;
  assign rise    = z && !z_q;
  assign z_val   = last;
  assign run_cnt = cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= ST_EMPTY;
      last  <= 1'b0;
      cnt   <= '0;
      z_q   <= 1'b0;
    end else begin
      // z_q tracks z on every edge so a Mode-induced assertion still pulses rise.
      z_q <= z;
      if (En) begin
        if (state == ST_EMPTY || w != last) begin
          // A fresh run already contains the bit just sampled.
          state <= ST_RUN;
          last  <= w;
          cnt   <= CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef RUNDET_EVT_CNT_EN
  // Counts rise pulses regardless of En; wraps naturally modulo 2**EVT_W.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      evt_cnt <= '0;
    end else if (rise) begin
      evt_cnt <= evt_cnt + EVT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_run_detector.sv
// -----------------------------------------------------------------------------
// tb_run_detector
//
// Directed self-checking bench for run_detector. Two instances share the
// stimulus: dut (defaults, RUN_LEN=4, CNT_W=4, EVT_W=2) and dut7 (CNT_W=3,
// RUN_LEN=7) for the saturation boundary. Inputs change on the falling edge;
// outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_run_detector;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       En = 1'b0;
  logic       w = 1'b0;
  logic [1:0] Mode = 2'b00;

  logic       z, z_val, rise;
  logic [3:0] run_cnt;
  logic       z7, z_val7, rise7;
  logic [2:0] run_cnt7;
`ifdef RUNDET_EVT_CNT_EN
  logic [1:0] evt_cnt;
  logic [7:0] evt_cnt7;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 Clock = ~Clock;

  run_detector #(.RUN_LEN(4), .CNT_W(4), .EVT_W(2)) dut (
    .Clock(Clock), .Resetn(Resetn), .En(En), .w(w), .Mode(Mode),
    .z(z), .z_val(z_val), .run_cnt(run_cnt), .rise(rise)
`ifdef RUNDET_EVT_CNT_EN
    , .evt_cnt(evt_cnt)
`endif
  );

  run_detector #(.RUN_LEN(7), .CNT_W(3)) dut7 (
    .Clock(Clock), .Resetn(Resetn), .En(En), .w(w), .Mode(Mode),
    .z(z7), .z_val(z_val7), .run_cnt(run_cnt7), .rise(rise7)
`ifdef RUNDET_EVT_CNT_EN
    , .evt_cnt(evt_cnt7)
`endif
  );

  // One clock edge with the given strobe and bit; returns after sampling time.
  task automatic step(input logic en_b, input logic w_b);
    @(negedge Clock);
    En = en_b;
    w  = w_b;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Resetn = 1'b0;
    En     = 1'b1;
    w      = 1'b1;
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (run_cnt !== 4'd0 || z !== 1'b0 || z_val !== 1'b0 || rise !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: run_cnt=%0d z=%b z_val=%b rise=%b, required 0 0 0 0",
               run_cnt, z, z_val, rise);
    end
    vectors++;
    if (run_cnt7 !== 3'd0 || z7 !== 1'b0 || z_val7 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset7: run_cnt=%0d z=%b z_val=%b, required 0 0 0",
               run_cnt7, z7, z_val7);
    end
  endtask

  task automatic test_basic_run();
    do_reset();
    Mode = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1);
      vectors++;
      if (run_cnt !== 4'(i) || z !== (i == 4) || rise !== (i == 4) || z_val !== 1'b1) begin
        miscompares++;
        $display("FAIL basic[%0d]: run_cnt=%0d z=%b rise=%b z_val=%b, required %0d %b %b 1",
                 i, run_cnt, z, rise, z_val, i, (i == 4), (i == 4));
      end
    end
    step(1'b0, 1'b0);
    vectors++;
    if (rise !== 1'b0 || z !== 1'b1 || run_cnt !== 4'd4) begin
      miscompares++;
      $display("FAIL basic_after: rise=%b z=%b run_cnt=%0d, required 0 1 4", rise, z, run_cnt);
    end
  endtask

  task automatic test_mode_change();
    do_reset();
    Mode = 2'b01;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    vectors++;
    if (run_cnt !== 4'd5 || z !== 1'b0 || z_val !== 1'b0) begin
      miscompares++;
      $display("FAIL mode01: run_cnt=%0d z=%b z_val=%b, required 5 0 0", run_cnt, z, z_val);
    end
    Mode = 2'b00;
    #1;
    vectors++;
    if (z !== 1'b1 || rise !== 1'b1 || run_cnt !== 4'd5) begin
      miscompares++;
      $display("FAIL mode00: z=%b rise=%b run_cnt=%0d, required 1 1 5", z, rise, run_cnt);
    end
    step(1'b0, 1'b1);
    vectors++;
    if (z !== 1'b1 || rise !== 1'b0) begin
      miscompares++;
      $display("FAIL mode00_hold: z=%b rise=%b, required 1 0", z, rise);
    end
    Mode = 2'b11;
    #1;
    vectors++;
    if (z !== 1'b0 || run_cnt !== 4'd5) begin
      miscompares++;
      $display("FAIL mode11: z=%b run_cnt=%0d, required 0 5", z, run_cnt);
    end
    step(1'b0, 1'b1);
    Mode = 2'b10;
    #1;
    vectors++;
    if (z !== 1'b1 || rise !== 1'b1 || z_val !== 1'b0) begin
      miscompares++;
      $display("FAIL mode10: z=%b rise=%b z_val=%b, required 1 1 0", z, rise, z_val);
    end
    Mode = 2'b00;
  endtask

  task automatic test_broken_run();
    logic [7:0] bits;
    logic [3:0] exp_cnt [8];
    bits    = 8'b1111_0111;  // applied LSB first: 1,1,1,0,1,1,1,1
    exp_cnt = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, bits[i]);
      vectors++;
      if (run_cnt !== exp_cnt[i] || z !== (i == 7) || z_val !== bits[i]) begin
        miscompares++;
        $display("FAIL broken[%0d]: run_cnt=%0d z=%b z_val=%b, required %0d %b %b",
                 i, run_cnt, z, z_val, exp_cnt[i], (i == 7), bits[i]);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0);
      vectors++;
      if (run_cnt7 !== 3'((i < 7) ? i : 7) || z7 !== (i >= 7) || rise7 !== (i == 7)) begin
        miscompares++;
        $display("FAIL sat7[%0d]: run_cnt=%0d z=%b rise=%b, required %0d %b %b",
                 i, run_cnt7, z7, rise7, (i < 7) ? i : 7, (i >= 7), (i == 7));
      end
    end
    // Default instance: run continues past 15 and holds at the ceiling.
    for (int i = 11; i <= 17; i++) step(1'b1, 1'b0);
    vectors++;
    if (run_cnt !== 4'd15 || z !== 1'b1 || rise !== 1'b0) begin
      miscompares++;
      $display("FAIL sat15: run_cnt=%0d z=%b rise=%b, required 15 1 0", run_cnt, z, rise);
    end
  endtask

  task automatic test_enable_hold();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, i[0]);
      vectors++;
      if (run_cnt !== 4'd3 || z !== 1'b0 || z_val !== 1'b1) begin
        miscompares++;
        $display("FAIL en_hold[%0d]: run_cnt=%0d z=%b z_val=%b, required 3 0 1",
                 i, run_cnt, z, z_val);
      end
    end
    step(1'b1, 1'b1);
    vectors++;
    if (run_cnt !== 4'd4 || z !== 1'b1 || rise !== 1'b1) begin
      miscompares++;
      $display("FAIL en_resume: run_cnt=%0d z=%b rise=%b, required 4 1 1", run_cnt, z, rise);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    vectors++;
    if (z !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_pre: z=%b, required 1", z);
    end
    do_reset();
    vectors++;
    if (run_cnt !== 4'd0 || z !== 1'b0 || z_val !== 1'b0 || rise !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_rst: run_cnt=%0d z=%b z_val=%b rise=%b, required 0 0 0 0",
               run_cnt, z, z_val, rise);
    end
    // First bit after reset is a fresh run even though it equals the reset last value.
    step(1'b1, 1'b0);
    vectors++;
    if (run_cnt !== 4'd1 || z_val !== 1'b0 || z !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_fresh: run_cnt=%0d z_val=%b z=%b, required 1 0 0",
               run_cnt, z_val, z);
    end
  endtask

`ifdef RUNDET_EVT_CNT_EN
  task automatic test_evt_cnt();
    logic [1:0] exp_evt [5];
    exp_evt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    Mode = 2'b00;
    vectors++;
    if (evt_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL evt_reset: evt_cnt=%0d, required 0", evt_cnt);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    vectors++;
    if (evt_cnt !== exp_evt[0]) begin
      miscompares++;
      $display("FAIL evt[0]: evt_cnt=%0d, required %0d", evt_cnt, exp_evt[0]);
    end
    // Further detections come from masking and unmasking the standing run.
    for (int k = 1; k < 5; k++) begin
      Mode = 2'b11;
      step(1'b0, 1'b1);
      Mode = 2'b00;
      step(1'b0, 1'b1);
      vectors++;
      if (evt_cnt !== exp_evt[k]) begin
        miscompares++;
        $display("FAIL evt[%0d]: evt_cnt=%0d, required %0d", k, evt_cnt, exp_evt[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_run();
    test_mode_change();
    test_broken_run();
    test_saturation();
    test_enable_hold();
    test_reset_midrun();
`ifdef RUNDET_EVT_CNT_EN
    test_evt_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
